// File: rtl/comp_ctrl_p.sv
// ---------------------------------------------------------------------------
// comp_ctrl_p -- pixel/phrase write-compare control.
//
// Decides, per byte lane, whether a write must be inhibited, from three
// sources: a bit-compare against one selected bit of a source word, a
// per-byte data-compare, and a per-16-bit Z-compare. It also keeps a walking
// bit pointer for the bit-compare and counts the inhibited pixel writes.
//
// Parameters
//   NBYTES : byte lanes per phrase (4, 8 or 16)
//   BW     : bit-compare source width (8 or 16)
//   CNTW   : inhibit counter width
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   in_valid            : compare inputs valid this cycle
//   cmp_start           : load bit pointer from icount_init, clear inh_cnt
//   icount_init         : bit pointer load value
//   step_inner          : advance bit pointer (mod BW)
//   big_pix             : bit order, 0 = MSB first, 1 = LSB first
//   phrase_mode         : 1 = phrase writes, 0 = pixel writes
//   pixsize             : 3 = 8bpp, 4 = 16bpp, 5 = 32bpp, other = 8bpp
//   bcompen/dcompen     : bit-compare / data-compare enables
//   bkgwren             : background write enable (suppresses nowrite)
//   bcompinv            : bit-compare polarity
//   srcd                : bit-compare source
//   dcomp               : per-byte data-compare equal flags
//   zcomp               : per-16-bit Z-compare fail flags
//   dbinh_n             : registered per-byte write enable (0 = inhibit)
//   nowrite             : registered whole-pixel write suppression
//   out_valid           : in_valid delayed one cycle
//   bitptr              : current bit pointer
//   inh_cnt             : saturating count of inhibited pixel writes
// ---------------------------------------------------------------------------
module comp_ctrl_p #(
    parameter int NBYTES = 8,
    parameter int BW     = 8,
    parameter int CNTW   = 16,
    localparam int SELW  = $clog2(BW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              cmp_start,
    input  logic [SELW-1:0]   icount_init,
    input  logic              step_inner,
    input  logic              big_pix,
    input  logic              phrase_mode,
    input  logic [2:0]        pixsize,
    input  logic              bcompen,
    input  logic              dcompen,
    input  logic              bkgwren,
    input  logic              bcompinv,
    input  logic [BW-1:0]     srcd,
    input  logic [NBYTES-1:0] dcomp,
    input  logic [NBYTES/2-1:0] zcomp,
    output logic [NBYTES-1:0] dbinh_n,
    output logic              nowrite,
    output logic              out_valid,
    output logic [SELW-1:0]   bitptr,
    output logic [CNTW-1:0]   inh_cnt
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SELW-1:0]   bitptr_q,  bitptr_d;
    logic [CNTW-1:0]   cnt_q,     cnt_d;
    logic [NBYTES-1:0] dbinh_n_q, dbinh_n_d;
    logic              nowrite_q, nowrite_d;
    logic              valid_q;

    // ------------------------------------------------------------------
    // Per-lane data/Z terms for each pixel size, and bit-compare per lane
    // ------------------------------------------------------------------
    logic [NBYTES-1:0] dz8, dz16, dz32, dz, bc_lane, lane_inh;

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        assign dz8[gi]  = dcompen & dcomp[gi];
        // 16bpp: lane belongs to word gi/2
        assign dz16[gi] = zcomp[gi/2] | (dcompen & (&dcomp[2*(gi/2) +: 2]));
        // 32bpp: lane belongs to dword gi/4, which spans two Z flags
        assign dz32[gi] = (&zcomp[2*(gi/4) +: 2])
                        | (dcompen & (&dcomp[4*(gi/4) +: 4]));
        // Phrase bit-compare uses one source bit per lane, wrapping at BW
        assign bc_lane[gi] = bcompen & (srcd[gi % BW] == bcompinv);
    end

    always_comb begin
        dz = dz8;
        case (pixsize)
            3'd4:    dz = dz16;
            3'd5:    dz = dz32;
            default: dz = dz8;
        endcase
    end

    assign lane_inh = dz | bc_lane;

    // ------------------------------------------------------------------
    // Pixel-mode bit compare on the bit selected by the (pre-update) pointer
    // ------------------------------------------------------------------
    logic [SELW-1:0] bit_idx;
    logic            bbit;
    logic            binh;
    logic            winhibit;

    assign bit_idx  = big_pix ? bitptr_q : (SELW'(BW - 1) - bitptr_q);
    assign bbit     = srcd[bit_idx];
    assign binh     = bcompen & (bbit == bcompinv);
    assign winhibit = phrase_mode ? 1'b0 : (binh | dz[0]);

    // A pixel occupies the low half of the phrase, so winhibit only
    // touches the lower NBYTES/2 lanes.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_dbinh
        if (gi < NBYTES / 2) begin : g_low
            assign dbinh_n_d[gi] = ~((phrase_mode & lane_inh[gi]) | winhibit);
        end else begin : g_high
            assign dbinh_n_d[gi] = ~(phrase_mode & lane_inh[gi]);
        end
    end

    assign nowrite_d = winhibit & ~bkgwren;

    // ------------------------------------------------------------------
    // Next-state for pointer and counter
    // ------------------------------------------------------------------
    always_comb begin
        bitptr_d = bitptr_q;
        if (cmp_start) begin
            bitptr_d = icount_init;
        end else if (step_inner) begin
            bitptr_d = bitptr_q + SELW'(1);   // BW is a power of two: wraps mod BW
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cmp_start) begin
            cnt_d = '0;
        end else if (in_valid && nowrite_d && !(&cnt_q)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bitptr_q  <= '0;
            cnt_q     <= '0;
            dbinh_n_q <= '1;
            nowrite_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            bitptr_q <= bitptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= in_valid;
            // Results only advance on accepted cycles; otherwise hold.
            if (in_valid) begin
                dbinh_n_q <= dbinh_n_d;
                nowrite_q <= nowrite_d;
            end
        end
    end

    assign dbinh_n   = dbinh_n_q;
    assign nowrite   = nowrite_q;
    assign out_valid = valid_q;
    assign bitptr    = bitptr_q;
    assign inh_cnt   = cnt_q;

endmodule

// File: tb/tb_comp_ctrl_p.sv
// ---------------------------------------------------------------------------
// tb_comp_ctrl_p -- self-checking bench for comp_ctrl_p (NBYTES=8, BW=8,
// CNTW=4 so that counter saturation is reachable in a few cycles).
// Expected {dbinh_n, nowrite} are pushed to a queue when a valid input is
// driven and popped when the DUT raises out_valid.
// ---------------------------------------------------------------------------
module tb_comp_ctrl_p;

    localparam int NB   = 8;
    localparam int BWP  = 8;
    localparam int CW   = 4;
    localparam int SW   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, cmp_start, step_inner, big_pix, phrase_mode;
    logic [SW-1:0] icount_init;
    logic [2:0]    pixsize;
    logic          bcompen, dcompen, bkgwren, bcompinv;
    logic [BWP-1:0] srcd;
    logic [NB-1:0] dcomp;
    logic [NB/2-1:0] zcomp;
    logic [NB-1:0] dbinh_n;
    logic          nowrite, out_valid;
    logic [SW-1:0] bitptr;
    logic [CW-1:0] inh_cnt;

    comp_ctrl_p #(.NBYTES(NB), .BW(BWP), .CNTW(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .cmp_start(cmp_start),
        .icount_init(icount_init), .step_inner(step_inner), .big_pix(big_pix),
        .phrase_mode(phrase_mode), .pixsize(pixsize), .bcompen(bcompen),
        .dcompen(dcompen), .bkgwren(bkgwren), .bcompinv(bcompinv),
        .srcd(srcd), .dcomp(dcomp), .zcomp(zcomp), .dbinh_n(dbinh_n),
        .nowrite(nowrite), .out_valid(out_valid), .bitptr(bitptr),
        .inh_cnt(inh_cnt)
    );

    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int txn        = 0;

    // Bench model state
    int        m_ptr;
    int        m_cnt;
    logic      m_ov;
    logic [8:0] sb_q[$];
    logic [8:0] last_out;   // {dbinh_n, nowrite} currently held by the DUT

    task automatic chk_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s txn=%0d got=0x%0h expected=0x%0h", tag, txn, act, exp);
        end
    endtask

    // Reference behaviour for one cycle, from current inputs and m_ptr.
    function automatic logic [8:0] model();
        logic [7:0] dz, lane, dbn;
        logic       win;
        int         idx, base;
        for (int i = 0; i < 8; i++) begin
            if (pixsize == 3'd4) begin
                dz[i] = zcomp[i/2] | (dcompen & dcomp[i & ~1] & dcomp[i | 1]);
            end else if (pixsize == 3'd5) begin
                base  = (i / 4) * 4;
                dz[i] = (zcomp[base/2] & zcomp[base/2 + 1])
                      | (dcompen & dcomp[base] & dcomp[base+1]
                                 & dcomp[base+2] & dcomp[base+3]);
            end else begin
                dz[i] = dcompen & dcomp[i];
            end
            lane[i] = dz[i] | (bcompen & (srcd[i] == bcompinv));
        end
        idx = big_pix ? m_ptr : (7 - m_ptr);
        win = !phrase_mode && ((bcompen && (srcd[idx] == bcompinv)) || dz[0]);
        for (int i = 0; i < 8; i++) begin
            dbn[i] = !((phrase_mode && lane[i]) || (i < 4 && win));
        end
        return {dbn, win & ~bkgwren};
    endfunction

    // One clock: push expectation, advance, update model, compare.
    task automatic step();
        logic [8:0] exp;
        logic [8:0] got;
        exp = model();
        if (in_valid && !reset) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        txn++;
        if (reset) begin
            m_ptr = 0; m_cnt = 0; m_ov = 1'b0;
            sb_q.delete();
            last_out = {8'hFF, 1'b0};
        end else begin
            if (cmp_start) m_cnt = 0;
            else if (in_valid && exp[0] && m_cnt != 15) m_cnt++;
            if (cmp_start) m_ptr = icount_init;
            else if (step_inner) m_ptr = (m_ptr + 1) % 8;
            m_ov = in_valid;
        end
        chk_eq("out_valid", out_valid, m_ov);
        chk_eq("bitptr", bitptr, m_ptr);
        chk_eq("inh_cnt", inh_cnt, m_cnt);
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk_eq("sb_underflow", 0, 1);
            end else begin
                last_out = sb_q.pop_front();
            end
        end
        got = {dbinh_n, nowrite};
        chk_eq("dbinh_n", dbinh_n, last_out[8:1]);
        chk_eq("nowrite", nowrite, last_out[0]);
        $display("txn %0d rst=%0d iv=%0d ov=%0d ptr=%0d dbinh_n=%02h nw=%0d cnt=%0d",
                 txn, reset, in_valid, out_valid, bitptr, got[8:1], got[0], inh_cnt);
    endtask

    task automatic set_idle();
        reset = 0; in_valid = 0; cmp_start = 0; step_inner = 0; big_pix = 0;
        phrase_mode = 0; icount_init = '0; pixsize = 3'd3; bcompen = 0;
        dcompen = 0; bkgwren = 0; bcompinv = 0; srcd = '0; dcomp = '0; zcomp = '0;
    endtask

    task automatic set_pix_inhibit();
        set_idle();
        bcompen = 1; bcompinv = 0; srcd = 8'h7F; in_valid = 1;
    endtask

    initial begin
        m_ptr = 0; m_cnt = 0; m_ov = 0; last_out = {8'hFF, 1'b0};
        set_idle();
        reset = 1;
        step();
        step();
        chk_eq("rst_dbinh", dbinh_n, 8'hFF);
        chk_eq("rst_cnt", inh_cnt, 0);

        // Pointer load and wrap
        set_idle(); cmp_start = 1; icount_init = 3'd5; step();
        chk_eq("ptr_load", bitptr, 5);
        set_idle(); step_inner = 1; step();
        chk_eq("ptr_6", bitptr, 6);
        step();
        chk_eq("ptr_7", bitptr, 7);
        step();
        chk_eq("ptr_wrap", bitptr, 0);

        // Pixel bit-compare inhibit
        set_idle(); cmp_start = 1; icount_init = 3'd0; step();
        set_pix_inhibit(); step();
        chk_eq("pix_dbinh", dbinh_n, 8'hF0);
        chk_eq("pix_nowrite", nowrite, 1);
        chk_eq("pix_cnt", inh_cnt, 1);

        // Phrase 16bpp
        set_idle(); phrase_mode = 1; pixsize = 3'd4; dcompen = 1;
        dcomp = 8'b0000_0011; zcomp = 4'b1000; in_valid = 1; step();
        chk_eq("ph16_dbinh", dbinh_n, 8'h3C);
        chk_eq("ph16_nowrite", nowrite, 0);

        // Phrase 32bpp, without and with bit compare
        set_idle(); phrase_mode = 1; pixsize = 3'd5; dcompen = 1;
        dcomp = 8'h0F; in_valid = 1; step();
        chk_eq("ph32_dbinh", dbinh_n, 8'hF0);
        bcompen = 1; bcompinv = 1; srcd = 8'h01; step();
        chk_eq("ph32_bc_dbinh", dbinh_n, 8'hF0);

        // Hold when in_valid=0
        set_idle(); srcd = 8'hAA; dcomp = 8'hFF; step();
        chk_eq("hold_dbinh", dbinh_n, 8'hF0);

        // Saturation, then clear beating increment
        for (int i = 0; i < 18; i++) begin
            set_pix_inhibit(); step();
        end
        chk_eq("sat_cnt", inh_cnt, 4'hF);
        set_pix_inhibit(); cmp_start = 1; step();
        chk_eq("clr_cnt", inh_cnt, 0);

        // Random traffic including occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            in_valid    = $urandom_range(0, 3) != 0;
            cmp_start   = ($urandom_range(0, 15) == 0);
            icount_init = SW'($urandom);
            step_inner  = $urandom_range(0, 1);
            big_pix     = $urandom_range(0, 1);
            phrase_mode = $urandom_range(0, 1);
            pixsize     = 3'($urandom);
            bcompen     = $urandom_range(0, 1);
            dcompen     = $urandom_range(0, 1);
            bkgwren     = ($urandom_range(0, 3) == 0);
            bcompinv    = $urandom_range(0, 1);
            srcd        = BWP'($urandom);
            dcomp       = NB'($urandom);
            zcomp       = 4'($urandom);
            step();
        end

        // Reset overriding everything mid-stream
        set_pix_inhibit(); step(); step();
        set_pix_inhibit(); reset = 1; cmp_start = 1; icount_init = 3'd6;
        step_inner = 1; step();
        chk_eq("rstov_ptr", bitptr, 0);
        chk_eq("rstov_dbinh", dbinh_n, 8'hFF);
        chk_eq("rstov_nowrite", nowrite, 0);
        chk_eq("rstov_ov", out_valid, 0);
        chk_eq("rstov_cnt", inh_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
